fifo_param_fwft: RTL and testbench
==================================

// Module: fifo_param_fwft
// PURPOSE
//  Next-generation synchronous FIFO. Width and depth are parametrised, and storage is held inside the block.
//  Read mode is selectable: registered read or first-word-fall-through (FWFT).
//  True full is reached at 2**ADDR_WIDTH entries. Overflow and underflow are reported on sticky error flags.
//  Sits between traffic producers and consumers in the datapath, in place of the fixed-size fifo + RAM_memory pair.
// PARAMETERS
//  DATA_WIDTH  6  bits per word
//  ADDR_WIDTH  3  pointer width; DEPTH = 2**ADDR_WIDTH entries
//  FWFT        0  0 = registered read (1-cycle latency); 1 = head word presented without a read
// PORTS
//  clk               in   1             rising-edge clock
//  reset             in   1             synchronous, active-high reset
//  wr_en             in   1             write request
//  wr_data           in   DATA_WIDTH    word to push
//  rd_en             in   1             read request (FWFT=1: pop/acknowledge of the head word)
//  umb_almost_full   in   ADDR_WIDTH+1  almost-full threshold
//  umb_almost_empty  in   ADDR_WIDTH+1  almost-empty threshold
//  err_clear         in   1             clears both sticky error flags
//  rd_data           out  DATA_WIDTH    popped word (FWFT=0) / head word (FWFT=1)
//  rd_valid          out  1             rd_data is valid
//  data_count        out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  full, empty, almost_full, almost_empty  out  1  status flags
//  overflow_err      out  1             sticky: a write was dropped
//  underflow_err     out  1             sticky: a read was made on empty
// BEHAVIOUR
//  Reset (posedge clk with reset=1): reset beats every other input that cycle.
//   - wr_ptr, rd_ptr, data_count, rd_data, rd_valid, overflow_err, underflow_err all go to 0.
//   - Giving empty=1 and full=almost_full=almost_empty=0.
//   - Mid-operation reset discards all contents. Memory array is not cleared.
//  Accept rules, evaluated each cycle on registered state:
//   - rd_acc = rd_en & !empty.
//   - wr_acc = wr_en & (!full | rd_acc): a write on full is accepted only together with an accepted read.
//  Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//   - Never exceeds DEPTH and never goes below 0.
//  Pointers: each advances by 1 on its accept and wraps modulo DEPTH. Write stores wr_data at mem[wr_ptr].
//  Write on empty with rd_en=1: write accepted, read rejected (underflow_err set). Count becomes 1.
//  Flags: combinational decode of registered data_count, so they reflect an operation the cycle after it.
//   - empty        = (count == 0)
//   - full         = (count == DEPTH)
//   - almost_full  = (count >= umb_almost_full)
//   - almost_empty = (count <= umb_almost_empty) & (count != 0)
//   - Thresholds are used live, not latched.
//  FWFT=0 read path:
//   - On rd_acc, rd_data <= mem[rd_ptr] at that edge; rd_valid=1 for exactly the following cycle.
//   - Otherwise rd_valid=0 and rd_data holds its last value.
//  FWFT=1 read path:
//   - rd_data = mem[rd_ptr] combinational; rd_valid = !empty.
//   - rd_acc advances to the next word. A word written into an empty FIFO is visible the cycle after its write.
//  Errors:
//   - overflow_err <= 1 when wr_en & !wr_acc.
//   - underflow_err <= 1 when rd_en & empty.
//   - err_clear zeroes both. Set beats clear when both happen in the same cycle.
//   - Errors never change pointers or count.
// TESTING
//  T1 reset: drive reset=1 for 2 cycles with wr_en=rd_en=1
//     -> count=0, empty=1, rd_valid=0, errs=0. No pointer movement.
//  T2 fill, DEPTH=8, DATA_WIDTH=6, umb_af=6, umb_ae=2: write 0x01..0x08 on consecutive cycles
//     -> almost_empty=1 at count 1..2; almost_full=1 from count 6; full=1 at count 8.
//     -> 9th write: overflow_err=1, count stays 8.
//  T3 drain, FWFT=0: read 8 times
//     -> rd_data is 0x01..0x08, each one cycle after its rd_en, with rd_valid pulsed.
//     -> Then empty=1. Extra read sets underflow_err; rd_data holds 0x08.
//  T4 simultaneous ops: on full, wr_en=rd_en=1 -> count stays 8, no overflow, oldest word out.
//     On empty, both=1 -> count becomes 1, underflow_err=1.
//  T5 FWFT=1: write 0x2A into empty
//     -> next cycle rd_valid=1, rd_data=0x2A with no rd_en. After rd_en, empty=1 and rd_valid=0.
//  T6 wrap/errors: 20 interleaved writes/reads with count held at 3
//     -> data order preserved across pointer wrap.
//     -> err_clear together with a new overflow leaves overflow_err=1; err_clear alone clears it.

Source files
------------

// File: rtl/fifo_param_fwft.sv
// Parametrised synchronous FIFO with internal storage and selectable read mode:
// registered read (FWFT=0, one-cycle latency) or first-word-fall-through (FWFT=1).
// Occupancy-decoded status flags, live thresholds, sticky overflow/underflow flags.
//
// Handshake: a write is taken on any rising edge where wr_en is high and the
// FIFO can accept it (not full, or full with a read accepted on the same edge).
// A read is taken on any rising edge where rd_en is high and the FIFO is not empty.
// rd_valid qualifies rd_data: FWFT=0 pulses for the one cycle after an accepted
// read; FWFT=1 stays high while a head word is present, and rd_en pops it.
module fifo_param_fwft #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_COUNT  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Accept decisions and status flags, all decoded from registered occupancy.
  always_comb begin
    empty        = (data_count == '0);
    full         = (data_count == FULL_COUNT);
    almost_full  = (data_count >= umb_almost_full);
    almost_empty = (data_count <= umb_almost_empty) && (data_count != '0);
    rd_acc       = rd_en && !empty;
    wr_acc       = wr_en && (!full || rd_acc);
  end

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; count moves only on a lone write or lone read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_PTR;
      if (rd_acc) rd_ptr <= rd_ptr + ONE_PTR;
      case ({wr_acc, rd_acc})
        2'b10:   data_count <= data_count + ONE_COUNT;
        2'b01:   data_count <= data_count - ONE_COUNT;
        default: data_count <= data_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow_err <= 1'b1;
      else if (err_clear)   overflow_err <= 1'b0;
      if (rd_en && empty)   underflow_err <= 1'b1;
      else if (err_clear)   underflow_err <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly from storage while the FIFO holds data.
    always_comb begin
      rd_data  = mem[rd_ptr];
      rd_valid = !empty;
    end
  end else begin : g_reg
    // Registered read: the popped word appears the cycle after its accept and then holds.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_param_fwft.sv
// Bench for fifo_param_fwft: a registered-read instance and an FWFT instance
// share every input, so their occupancy and flags track identically while
// their read paths differ.
module tb_fifo_param_fwft;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [3:0] umb_almost_full = 4'd6;
  logic [3:0] umb_almost_empty = 4'd2;
  logic       err_clear = 1'b0;

  logic [5:0] rd_data, f_rd_data;
  logic       rd_valid, f_rd_valid;
  logic [3:0] data_count, f_data_count;
  logic       full, empty, almost_full, almost_empty, overflow_err, underflow_err;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow_err, f_underflow_err;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  fifo_param_fwft #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .umb_almost_full(umb_almost_full), .umb_almost_empty(umb_almost_empty),
    .err_clear(err_clear), .rd_data(rd_data), .rd_valid(rd_valid),
    .data_count(data_count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  fifo_param_fwft #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .FWFT(1)) dut_f (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .umb_almost_full(umb_almost_full), .umb_almost_empty(umb_almost_empty),
    .err_clear(err_clear), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .data_count(f_data_count), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .overflow_err(f_overflow_err), .underflow_err(f_underflow_err)
  );

  typedef struct {
    logic       rst, we;
    logic [5:0] wd;
    logic       re, ec;
    logic [3:0] cnt;
    logic       emp, ful, af, ae, rv;
    logic [5:0] rd;
    logic       chk_rd;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] exp_q[$];

  function automatic vec_t mk(logic rst, logic we, logic [5:0] wd, logic re, logic ec,
                              logic [3:0] cnt, logic emp, logic ful, logic af, logic ae,
                              logic rv, logic [5:0] rd, logic chk_rd, logic ovf, logic unf);
    vec_t v;
    v.rst = rst; v.we = we; v.wd = wd; v.re = re; v.ec = ec;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.af = af; v.ae = ae;
    v.rv = rv; v.rd = rd; v.chk_rd = chk_rd; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver: present inputs, take one edge, settle away from the edge
  task automatic drive(input logic rst, input logic we, input logic [5:0] wd,
                       input logic re, input logic ec);
    reset = rst; wr_en = we; wr_data = wd; rd_en = re; err_clear = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // ---------------- table: reset, fill, drain, simultaneous ops ----------------
    // T1 reset held with wr_en/rd_en high
    vecs.push_back(mk(1,1,6'h3F,1,0, 0,1,0,0,0, 0,6'h00,1, 0,0));
    vecs.push_back(mk(1,1,6'h3F,1,0, 0,1,0,0,0, 0,6'h00,1, 0,0));
    // T2 fill 0x01..0x08, then overflow
    vecs.push_back(mk(0,1,6'h01,0,0, 1,0,0,0,1, 0,6'h00,1, 0,0));
    vecs.push_back(mk(0,1,6'h02,0,0, 2,0,0,0,1, 0,6'h00,0, 0,0));
    vecs.push_back(mk(0,1,6'h03,0,0, 3,0,0,0,0, 0,6'h00,0, 0,0));
    vecs.push_back(mk(0,1,6'h04,0,0, 4,0,0,0,0, 0,6'h00,0, 0,0));
    vecs.push_back(mk(0,1,6'h05,0,0, 5,0,0,0,0, 0,6'h00,0, 0,0));
    vecs.push_back(mk(0,1,6'h06,0,0, 6,0,0,1,0, 0,6'h00,0, 0,0));
    vecs.push_back(mk(0,1,6'h07,0,0, 7,0,0,1,0, 0,6'h00,0, 0,0));
    vecs.push_back(mk(0,1,6'h08,0,0, 8,0,1,1,0, 0,6'h00,0, 0,0));
    vecs.push_back(mk(0,1,6'h09,0,0, 8,0,1,1,0, 0,6'h00,0, 1,0));
    vecs.push_back(mk(0,0,6'h00,0,1, 8,0,1,1,0, 0,6'h00,0, 0,0));
    // T3 drain in order
    vecs.push_back(mk(0,0,6'h00,1,0, 7,0,0,1,0, 1,6'h01,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 6,0,0,1,0, 1,6'h02,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 5,0,0,0,0, 1,6'h03,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 4,0,0,0,0, 1,6'h04,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 3,0,0,0,0, 1,6'h05,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 2,0,0,0,1, 1,6'h06,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 1,0,0,0,1, 1,6'h07,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 0,1,0,0,0, 1,6'h08,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,0,0, 0,1,0,0,0, 0,6'h08,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 0,1,0,0,0, 0,6'h08,1, 0,1));
    vecs.push_back(mk(0,0,6'h00,0,1, 0,1,0,0,0, 0,6'h08,1, 0,0));
    // T4 both on empty: write taken, read rejected
    vecs.push_back(mk(0,1,6'h21,1,0, 1,0,0,0,1, 0,6'h08,1, 0,1));
    vecs.push_back(mk(0,0,6'h00,1,1, 0,1,0,0,0, 1,6'h21,1, 0,0));
    // T4 refill 0x11..0x18, then both on full
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0,1,6'(16+i),0,0, 4'(i),0,(i==8),(i>=6),(i<=2),
                        0,6'h21,1, 0,0));
    vecs.push_back(mk(0,1,6'h19,1,0, 8,0,1,1,0, 1,6'h11,1, 0,0));
    vecs.push_back(mk(0,0,6'h00,1,0, 7,0,0,1,0, 1,6'h12,1, 0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.we, v.wd, v.re, v.ec);
      chk($sformatf("v%0d count", i), data_count, v.cnt);
      chk($sformatf("v%0d empty", i), empty, v.emp);
      chk($sformatf("v%0d full", i), full, v.ful);
      chk($sformatf("v%0d almost_full", i), almost_full, v.af);
      chk($sformatf("v%0d almost_empty", i), almost_empty, v.ae);
      chk($sformatf("v%0d rd_valid", i), rd_valid, v.rv);
      if (v.chk_rd) chk($sformatf("v%0d rd_data", i), rd_data, v.rd);
      chk($sformatf("v%0d overflow_err", i), overflow_err, v.ovf);
      chk($sformatf("v%0d underflow_err", i), underflow_err, v.unf);
      chk($sformatf("v%0d fwft rd_valid", i), f_rd_valid, !v.emp);
    end

    // ---------------- T5: first-word-fall-through ----------------
    drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    chk("t5 fwft valid after reset", f_rd_valid, 0);
    drive(1'b0, 1'b1, 6'h2A, 1'b0, 1'b0);
    chk("t5 fwft valid no rd_en", f_rd_valid, 1);
    chk("t5 fwft head", f_rd_data, 6'h2A);
    chk("t5 reg valid no rd_en", rd_valid, 0);
    drive(1'b0, 1'b1, 6'h2B, 1'b0, 1'b0);
    chk("t5 fwft head held", f_rd_data, 6'h2A);
    drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    chk("t5 fwft next head", f_rd_data, 6'h2B);
    chk("t5 reg popped", rd_data, 6'h2A);
    drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    chk("t5 fwft empty", f_empty, 1);
    chk("t5 fwft valid drop", f_rd_valid, 0);
    idle();

    // ---------------- T6: wrap with count held at 3 ----------------
    drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 6'(32 + i), 1'b0, 1'b0);
      exp_q.push_back(6'(32 + i));
    end
    for (int i = 3; i < 23; i++) begin
      logic [5:0] popped;
      chk($sformatf("t6 fwft head %0d", i), f_rd_data, exp_q[0]);
      popped = exp_q.pop_front();
      exp_q.push_back(6'(32 + i));
      drive(1'b0, 1'b1, 6'(32 + i), 1'b1, 1'b0);
      chk($sformatf("t6 rd_data %0d", i), rd_data, popped);
      chk($sformatf("t6 count %0d", i), data_count, 3);
    end
    for (int i = 23; i < 28; i++) begin
      drive(1'b0, 1'b1, 6'(32 + i), 1'b0, 1'b0);
      exp_q.push_back(6'(32 + i));
    end
    chk("t6 full", full, 1);
    drive(1'b0, 1'b1, 6'h3F, 1'b0, 1'b0);
    chk("t6 overflow set", overflow_err, 1);
    drive(1'b0, 1'b1, 6'h3F, 1'b0, 1'b1);
    chk("t6 set beats clear", overflow_err, 1);
    chk("t6 count after overflow", data_count, 8);
    drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    chk("t6 clear alone", overflow_err, 0);
    while (exp_q.size() > 0) begin
      logic [5:0] popped;
      popped = exp_q.pop_front();
      drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      chk("t6 drain order", rd_data, popped);
    end
    chk("t6 empty at end", empty, 1);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
